// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver states and baud divider helper.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    function automatic int baud_div(input int clock_hz, input int baud);
        return clock_hz / (baud * OVERSAMPLE);
    endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, parallel byte out with level ready and sticky faults.
interface uart_rx_if;
    logic       rx;
    logic       rdyClr;
    logic [0:7] dout;
    logic       rdy;
    logic       frameErr;
    logic       overrun;
    modport master (output rx, rdyClr, input dout, rdy, frameErr, overrun);
    modport slave (input rx, rdyClr, output dout, rdy, frameErr, overrun);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider, one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clock,
    input  logic resetN,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, level ready handshake and sticky faults.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input logic       clock,
    input logic       resetN,
    uart_rx_if.slave  bus
);
    localparam int DIV = baud_div(CLOCK_HZ, BAUD);
    logic [1:0] sync;
    logic       rxs, tick, shift, done, ferr;
    rx_state_t  state, state_n;
    logic [3:0] scnt, scnt_n;
    logic [2:0] idx, idx_n;
    logic [0:7] sh;
    assign rxs = sync[1];
    uart_baud_tick #(.DIV(DIV)) u_tick (.clock, .resetN, .tick);
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) sync <= 2'b11;
        else sync <= {sync[0], bus.rx};
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) begin
            state <= IDLE;
            scnt  <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            scnt  <= scnt_n;
            idx   <= idx_n;
            if (shift) sh <= {rxs, sh[0:6]};
        end
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        idx_n   = idx;
        shift   = 1'b0;
        done    = 1'b0;
        ferr    = 1'b0;
        if (tick)
            case (state)
                IDLE: if (!rxs) begin
                    state_n = START;
                    scnt_n  = '0;
                end
                START: if (scnt == 4'(MID_SAMPLE)) begin
                    state_n = rxs ? IDLE : DATA;
                    scnt_n  = '0;
                    idx_n   = '0;
                end else scnt_n = scnt + 4'd1;
                DATA: if (scnt == 4'(OVERSAMPLE - 1)) begin
                    shift   = 1'b1;
                    scnt_n  = '0;
                    idx_n   = idx + 3'd1;
                    state_n = idx == 3'd7 ? STOP : DATA;
                end else scnt_n = scnt + 4'd1;
                default: if (scnt == 4'(OVERSAMPLE - 1)) begin
                    state_n = IDLE;
                    scnt_n  = '0;
                    done    = rxs;
                    ferr    = !rxs;
                end else scnt_n = scnt + 4'd1;
            endcase
    end
    // a completed byte is only accepted when the previous one has been (or is being) taken
    always_ff @(posedge clock or negedge resetN)
        if (!resetN) begin
            bus.dout     <= '0;
            bus.rdy      <= 1'b0;
            bus.frameErr <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            if (done && (!bus.rdy || bus.rdyClr)) begin
                bus.dout <= sh;
                bus.rdy  <= 1'b1;
            end else if (bus.rdyClr) bus.rdy <= 1'b0;
            bus.overrun  <= (done && bus.rdy && !bus.rdyClr) || (bus.overrun && !bus.rdyClr);
            bus.frameErr <= ferr || (bus.frameErr && !bus.rdyClr);
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-derived expectations.
module tb_uart_rx;
    import uart_pkg::*;
    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUDR   = 230400;
    localparam int DIV     = 13;
    localparam int BIT     = 16 * DIV;
    localparam int LAT_MIN = 152 * DIV + 3;
    localparam int LAT_MAX = 153 * DIV + 2;
    logic clock = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0, errors = 0, cyc = 0, t0 = 0, t1 = 0;
    uart_rx_if bus();
    uart_rx #(.CLOCK_HZ(CLK_HZ), .BAUD(BAUDR)) dut (.clock(clock), .resetN(resetN), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick_n(input int n);
        repeat (n) @(negedge clock);
    endtask
    task automatic send(input logic [7:0] b, input logic stop);
        t0 = cyc;
        bus.rx = 1'b0;
        tick_n(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick_n(BIT);
        end
        bus.rx = stop;
        tick_n(BIT);
        bus.rx = 1'b1;
    endtask
    task automatic wait_rdy(input int lim);
        for (int i = 0; i < lim && bus.rdy !== 1'b1; i++) @(negedge clock);
        t1 = cyc;
    endtask
    task automatic clr;
        bus.rdyClr = 1'b1;
        tick_n(1);
        bus.rdyClr = 1'b0;
    endtask
    initial begin
        bus.rx = 1'b1;
        bus.rdyClr = 1'b0;
        tick_n(4);
        check("rst_dout", 32'(bus.dout), 32'h00);
        check("rst_rdy", 32'(bus.rdy), 32'd0);
        check("rst_ferr", 32'(bus.frameErr), 32'd0);
        check("rst_ovr", 32'(bus.overrun), 32'd0);
        resetN = 1'b1;
        tick_n(BIT);
        fork
            send(8'h53, 1'b1);
            wait_rdy(3 * 10 * BIT);
        join
        $display("latency %0d clocks", t1 - t0);
        check("lat_53", 32'(t1 - t0 >= LAT_MIN && t1 - t0 <= LAT_MAX), 32'd1);
        check("rdy_53", 32'(bus.rdy), 32'd1);
        check("dout_53", 32'(bus.dout), 32'h53);
        check("ferr_53", 32'(bus.frameErr), 32'd0);
        check("ovr_53", 32'(bus.overrun), 32'd0);
        clr;
        check("clr_rdy", 32'(bus.rdy), 32'd0);
        check("clr_dout", 32'(bus.dout), 32'h53);
        fork
            for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
            for (int j = 0; j < 16; j++) begin
                wait_rdy(3 * 10 * BIT);
                check("b2b_rdy", 32'(bus.rdy), 32'd1);
                tick_n(2);
                check("b2b_dout", 32'(bus.dout), 32'(j));
                clr;
            end
        join
        check("b2b_ovr", 32'(bus.overrun), 32'd0);
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        check("ovr_dout", 32'(bus.dout), 32'hA5);
        check("ovr_rdy", 32'(bus.rdy), 32'd1);
        check("ovr_flag", 32'(bus.overrun), 32'd1);
        check("ovr_ferr", 32'(bus.frameErr), 32'd0);
        clr;
        check("ovr_clr_rdy", 32'(bus.rdy), 32'd0);
        check("ovr_clr_flag", 32'(bus.overrun), 32'd0);
        check("ovr_clr_ferr", 32'(bus.frameErr), 32'd0);
        send(8'hFF, 1'b0);
        check("fe_flag", 32'(bus.frameErr), 32'd1);
        check("fe_rdy", 32'(bus.rdy), 32'd0);
        check("fe_ovr", 32'(bus.overrun), 32'd0);
        tick_n(2 * BIT);
        send(8'h12, 1'b1);
        check("fe_next_rdy", 32'(bus.rdy), 32'd1);
        check("fe_next_dout", 32'(bus.dout), 32'h12);
        check("fe_sticky", 32'(bus.frameErr), 32'd1);
        fork
            send(8'h77, 1'b1);
            begin
                tick_n(4 * BIT);
                check("pre_rst_state", 32'(dut.state), 32'(DATA));
                resetN = 1'b0;
                #1;
                check("mid_rst_dout", 32'(bus.dout), 32'h00);
                check("mid_rst_rdy", 32'(bus.rdy), 32'd0);
                check("mid_rst_ferr", 32'(bus.frameErr), 32'd0);
                check("mid_rst_ovr", 32'(bus.overrun), 32'd0);
                check("mid_rst_state", 32'(dut.state), 32'(IDLE));
            end
        join
        resetN = 1'b1;
        tick_n(BIT);
        send(8'h77, 1'b1);
        check("post_rst_rdy", 32'(bus.rdy), 32'd1);
        check("post_rst_dout", 32'(bus.dout), 32'h77);
        check("post_rst_ferr", 32'(bus.frameErr), 32'd0);
        check("post_rst_ovr", 32'(bus.overrun), 32'd0);
        clr;
        bus.rx = 1'b0;
        tick_n(3 * DIV);
        check("glitch_start", 32'(dut.state), 32'(START));
        bus.rx = 1'b1;
        tick_n(2 * BIT);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        check("glitch_rdy", 32'(bus.rdy), 32'd0);
        check("glitch_ferr", 32'(bus.frameErr), 32'd0);
        check("glitch_ovr", 32'(bus.overrun), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
